mac_vec_pipe: RTL and testbench

Parametrised, pipelined, saturating multiply-accumulate engine that computes signed dot products over variable-length vectors for neuron evaluation. Vector boundaries come from an `in_last` marker. Each completed sum is presented on a held output register while the next vector accumulates with no bubble. The block replaces fixed-width single-accumulator MAC units inside neuron datapaths.

---
 rtl/mac_vec_pipe.sv | 157 +++++++++++++++
 tb/tb_mac_vec_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mac_vec_pipe.sv
// Pipelined signed dot-product engine: input register, MULT_STAGES-deep multiplier,
// saturating (or wrapping) accumulator with per-vector overflow flag and element count.
module mac_vec_pipe #(
  parameter int DW          = 14,
  parameter int AW          = 28,
  parameter int MULT_STAGES = 2,
  parameter int SATURATE    = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  input  logic             in_last,
  output logic [AW-1:0]    f,
  output logic             valid_out,
  output logic             ovf_out,
  output logic [CNT_W-1:0] cnt_out
);

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] a_r;
  logic signed [DW-1:0] b_r;
  logic                 v_r;
  logic                 l_r;

  // NOTE: only control bits (valids/lasts) need reset; data registers are
  // qualified by their valid, so leaving them unreset is safe and cheaper.
  always_ff @(posedge clk) begin
    a_r <= a;
    b_r <= b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_r <= 1'b0;
      l_r <= 1'b0;
    end else begin
      v_r <= valid_in;
      l_r <= valid_in & in_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier pipeline with aligned valid/last sideband
  // ---------------------------------------------------------------------------
  logic signed [2*DW-1:0] prod_0;
  logic signed [2*DW-1:0] prod_q;
  logic                   acc_vld;
  logic                   acc_lst;

  assign prod_0 = (2*DW)'(a_r) * (2*DW)'(b_r);

  generate
    if (MULT_STAGES == 0) begin : g_no_mult_regs
      assign prod_q  = prod_0;
      assign acc_vld = v_r;
      assign acc_lst = l_r;
    end else begin : g_mult_regs
      logic signed [2*DW-1:0] p_pipe [MULT_STAGES];
      logic [MULT_STAGES-1:0] v_pipe;
      logic [MULT_STAGES-1:0] l_pipe;

      always_ff @(posedge clk) begin
        p_pipe[0] <= prod_0;
        for (int i = 1; i < MULT_STAGES; i++) begin
          p_pipe[i] <= p_pipe[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          v_pipe <= '0;
          l_pipe <= '0;
        end else begin
          v_pipe[0] <= v_r;
          l_pipe[0] <= l_r;
          for (int i = 1; i < MULT_STAGES; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            l_pipe[i] <= l_pipe[i-1];
          end
        end
      end

      assign prod_q  = p_pipe[MULT_STAGES-1];
      assign acc_vld = v_pipe[MULT_STAGES-1];
      assign acc_lst = l_pipe[MULT_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Accumulate stage
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] acc;
  logic                 acc_ovf;
  logic [CNT_W-1:0]     cnt;

  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] sum_raw;
  logic signed [AW-1:0] sum_res;
  logic                 ovf_now;
  logic                 ovf_next;
  logic [CNT_W-1:0]     cnt_next;

  assign prod_ext = AW'(prod_q);

  // The accumulator is cleared on reset and on every last element, so it
  // already holds 0 whenever the next element starts a new vector.
  always_comb begin
    base     = acc;
    sum_raw  = base + prod_ext;
    ovf_now  = (base[AW-1] == prod_ext[AW-1]) && (sum_raw[AW-1] != base[AW-1]);
    sum_res  = sum_raw;
    if (ovf_now && (SATURATE != 0)) begin
      sum_res = base[AW-1] ? ACC_MIN : ACC_MAX;
    end
    ovf_next = acc_ovf | ovf_now;
    cnt_next = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      acc_ovf   <= 1'b0;
      cnt       <= '0;
      f         <= '0;
      valid_out <= 1'b0;
      ovf_out   <= 1'b0;
      cnt_out   <= '0;
    end else begin
      valid_out <= 1'b0;
      if (acc_vld) begin
        if (acc_lst) begin
          f         <= sum_res;
          ovf_out   <= ovf_next;
          cnt_out   <= cnt_next;
          valid_out <= 1'b1;
          acc       <= '0;
          acc_ovf   <= 1'b0;
          cnt       <= '0;
        end else begin
          acc     <= sum_res;
          acc_ovf <= ovf_next;
          cnt     <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec_pipe.sv
// Self-checking bench for mac_vec_pipe: three instances (default, wrapping,
// zero multiplier stages) driven from a directed vector table plus corner sequences.
module tb_mac_vec_pipe;

  localparam int DW = 14;
  localparam int AW = 28;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    vin;
  logic [2:0]    lin;
  logic [DW-1:0] av [3];
  logic [DW-1:0] bv [3];
  logic [AW-1:0] fv [3];
  logic [2:0]    vo;
  logic [2:0]    ovf;
  logic [CW-1:0] cnt [3];

  mac_vec_pipe #(.DW(DW), .AW(AW), .MULT_STAGES(2), .SATURATE(1), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .valid_in(vin[0]), .a(av[0]), .b(bv[0]), .in_last(lin[0]),
    .f(fv[0]), .valid_out(vo[0]), .ovf_out(ovf[0]), .cnt_out(cnt[0]));

  mac_vec_pipe #(.DW(DW), .AW(AW), .MULT_STAGES(2), .SATURATE(0), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .valid_in(vin[1]), .a(av[1]), .b(bv[1]), .in_last(lin[1]),
    .f(fv[1]), .valid_out(vo[1]), .ovf_out(ovf[1]), .cnt_out(cnt[1]));

  mac_vec_pipe #(.DW(DW), .AW(AW), .MULT_STAGES(0), .SATURATE(1), .CNT_W(CW)) dut2 (
    .clk(clk), .reset(reset), .valid_in(vin[2]), .a(av[2]), .b(bv[2]), .in_last(lin[2]),
    .f(fv[2]), .valid_out(vo[2]), .ovf_out(ovf[2]), .cnt_out(cnt[2]));

  typedef struct {
    int dut;
    int f;
    int cnt;
    bit ovf;
    int cyc;
  } exp_t;

  typedef struct {
    int dut;
    int a;
    int b;
    bit last;
    int gap;
    int f;
    int cnt;
    bit ovf;
  } vec_t;

  exp_t expq[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard: every valid_out pulse must match the oldest pending result for
  // that instance, including the edge on which it was expected.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (vo[d] === 1'b1) begin
        int idx;
        idx = -1;
        foreach (expq[i]) if (idx < 0 && expq[i].dut == d) idx = i;
        check($sformatf("valid_out_expected_dut%0d", d), longint'(idx >= 0), 1);
        if (idx >= 0) begin
          check($sformatf("f_dut%0d", d), longint'($signed(fv[d])), longint'(expq[idx].f));
          check($sformatf("cnt_dut%0d", d), longint'(cnt[d]), longint'(expq[idx].cnt));
          check($sformatf("ovf_dut%0d", d), longint'(ovf[d]), longint'(expq[idx].ovf));
          check($sformatf("latency_dut%0d", d), longint'(cyc), longint'(expq[idx].cyc));
          expq.delete(idx);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = '0;
      lin = '0;
    end
  endtask

  task automatic drive(input int d, input int a, input int b, input bit last,
                       input int f, input int c, input bit o);
    @(negedge clk);
    vin    = '0;
    lin    = '0;
    vin[d] = 1'b1;
    av[d]  = DW'(a);
    bv[d]  = DW'(b);
    lin[d] = last;
    // Sampled at the next edge; result lands MULT_STAGES+1 edges after that.
    if (last) expq.push_back('{d, f, c, o, cyc + ((d == 2) ? 2 : 4)});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_f"}, longint'(fv[0]), 0);
    check({tag, "_valid_out"}, longint'(vo[0]), 0);
    check({tag, "_ovf_out"}, longint'(ovf[0]), 0);
    check({tag, "_cnt_out"}, longint'(cnt[0]), 0);
  endtask

  initial begin
    reset = 1'b1;
    vin   = '0;
    lin   = '0;
    for (int d = 0; d < 3; d++) begin
      av[d] = '0;
      bv[d] = '0;
    end

    //          dut  a      b      last gap f           cnt ovf
    tbl.push_back('{0, 3,     4,     0, 0, 0,          0, 0});
    tbl.push_back('{0, -5,    6,     0, 0, 0,          0, 0});
    tbl.push_back('{0, 7,     8,     1, 0, 38,         3, 0});
    tbl.push_back('{0, 3,     4,     0, 2, 0,          0, 0});
    tbl.push_back('{0, -5,    6,     0, 2, 0,          0, 0});
    tbl.push_back('{0, 7,     8,     1, 0, 38,         3, 0});
    tbl.push_back('{0, 2,     2,     1, 0, 4,          1, 0});
    tbl.push_back('{0, 1,     1,     1, 0, 1,          1, 0});
    tbl.push_back('{0, -8192, -8192, 0, 0, 0,          0, 0});
    tbl.push_back('{0, -8192, -8192, 1, 0, 134217727,  2, 1});
    tbl.push_back('{0, -100,  7,     1, 0, -700,       1, 0});
    tbl.push_back('{0, -8192, 8191,  0, 0, 0,          0, 0});
    tbl.push_back('{0, -8192, 8191,  0, 0, 0,          0, 0});
    tbl.push_back('{0, -8192, 8191,  1, 0, -134217728, 3, 1});
    tbl.push_back('{0, -8192, -8192, 0, 0, 0,          0, 0});
    tbl.push_back('{0, -8192, -8192, 0, 0, 0,          0, 0});
    tbl.push_back('{0, -1,    1,     1, 0, 134217726,  3, 1});
    tbl.push_back('{1, -8192, -8192, 0, 0, 0,          0, 0});
    tbl.push_back('{1, -8192, -8192, 1, 0, -134217728, 2, 1});
    tbl.push_back('{1, 1,     1,     1, 0, 1,          1, 0});
    tbl.push_back('{2, 5,     5,     1, 0, 25,         1, 0});
    tbl.push_back('{2, 3,     4,     0, 0, 0,          0, 0});
    tbl.push_back('{2, -5,    6,     0, 0, 0,          0, 0});
    tbl.push_back('{2, 7,     8,     1, 0, 38,         3, 0});

    // Reset held for several cycles keeps outputs at reset values.
    idle(2);
    check_reset_values("reset_hold1");
    idle(1);
    check_reset_values("reset_hold2");
    reset = 1'b0;
    idle(1);

    foreach (tbl[i]) begin
      drive(tbl[i].dut, tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].f, tbl[i].cnt, tbl[i].ovf);
      if (tbl[i].gap > 0) idle(tbl[i].gap);
    end
    idle(8);

    // Element counter saturates at 255 on a 301-element vector.
    for (int i = 0; i < 300; i++) drive(0, 1, 0, 1'b0, 0, 0, 1'b0);
    drive(0, 3, 3, 1'b1, 9, 255, 1'b0);
    idle(8);

    // Reset mid-vector: the aborted partial sum never reaches the output.
    drive(0, 9, 9, 1'b0, 0, 0, 1'b0);
    drive(0, 9, 9, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    vin   = '0;
    lin   = '0;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("mid_reset");
    reset = 1'b0;
    idle(1);
    drive(0, 5, 5, 1'b1, 25, 1, 1'b0);
    idle(1);

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    idle(3);
    check("results_drained", longint'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
